// File: rtl/filtro_pkg.sv
// -----------------------------------------------------------------------------
// filtro_pkg
// Shared definitions for the filter stages: FSM state encoding, default word
// sizes (N=25, F=20), derived widths and the 2N-bit saturation limits.
// -----------------------------------------------------------------------------
package filtro_pkg;

    localparam int N_DEF  = 25;
    localparam int F_DEF  = 20;

    localparam int W_SMP  = 2 * N_DEF;      // samples and result
    localparam int W_COEF = N_DEF;          // coefficients, Q(N-F).F
    localparam int W_PROD = 3 * N_DEF;      // one sample x coefficient product
    localparam int W_ACC  = 3 * N_DEF + 2;  // room for three products without wrap

    localparam logic signed [W_SMP-1:0] SAT_MAX = {1'b0, {(W_SMP-1){1'b1}}};
    localparam logic signed [W_SMP-1:0] SAT_MIN = {1'b1, {(W_SMP-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        MAC1 = 3'd2,
        MAC2 = 3'd3,
        OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/saturador_fk.sv
// -----------------------------------------------------------------------------
// saturador_fk
// Combinational fixed-point scaler: arithmetic right shift by SHIFT (floor
// rounding) followed by a clamp into the signed W_OUT-bit range.
//   acc     in   W_IN   signed accumulator value
//   y_sat   out  W_OUT  scaled and clamped value
//   ovf_sat out  1      high when the clamp was applied
// -----------------------------------------------------------------------------
module saturador_fk #(
    parameter int W_IN  = 77,
    parameter int W_OUT = 50,
    parameter int SHIFT = 20
) (
    input  logic signed [W_IN-1:0]  acc,
    output logic signed [W_OUT-1:0] y_sat,
    output logic                    ovf_sat
);

    // Output-range limits expressed in the input width so the comparison is
    // done without any truncation of the scaled value.
    localparam logic signed [W_IN-1:0] LIM_MAX =
        {{(W_IN-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_IN-1:0] LIM_MIN =
        {{(W_IN-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    logic signed [W_IN-1:0] scaled;

    assign scaled = acc >>> SHIFT;

    always_comb begin
        y_sat   = scaled[W_OUT-1:0];
        ovf_sat = 1'b0;
        if (scaled > LIM_MAX) begin
            y_sat   = LIM_MAX[W_OUT-1:0];
            ovf_sat = 1'b1;
        end else if (scaled < LIM_MIN) begin
            y_sat   = LIM_MIN[W_OUT-1:0];
            ovf_sat = 1'b1;
        end
    end

endmodule

// File: rtl/filtro_mac_fk.sv
// -----------------------------------------------------------------------------
// filtro_mac_fk
// Second-order MAC stage: y = c0*fk + c1*fk_1 + c2*fk_2, computed with one
// shared multiplier over three cycles, then scaled by 2^-F and saturated.
//   clk            in   1   system clock
//   reset          in   1   asynchronous active-high reset
//   start          in   1   compute one output from the current samples
//   fk, fk_1, fk_2 in   2N  signed samples (current, previous, before that)
//   c0, c1, c2     in   N   signed coefficients, Q(N-F).F
//   y              out  2N  saturated result, held until the next result
//   done           out  1   one-cycle pulse when y/ovf update
//   busy           out  1   computation in progress
//   ovf            out  1   last y was clamped
// -----------------------------------------------------------------------------
module filtro_mac_fk
    import filtro_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int F = F_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [2*N-1:0] fk,
    input  logic signed [2*N-1:0] fk_1,
    input  logic signed [2*N-1:0] fk_2,
    input  logic signed [N-1:0]   c0,
    input  logic signed [N-1:0]   c1,
    input  logic signed [N-1:0]   c2,
    output logic signed [2*N-1:0] y,
    output logic                  done,
    output logic                  busy,
    output logic                  ovf
);

    localparam int WS = 2 * N;
    localparam int WC = N;
    localparam int WP = 3 * N;
    localparam int WA = 3 * N + 2;

    state_t state_reg, state_next;

    logic signed [WS-1:0] smp_reg  [3];
    logic signed [WC-1:0] coef_reg [3];
    logic signed [WA-1:0] acc_reg;
    logic signed [WS-1:0] y_reg;
    logic                 ovf_reg;
    logic                 done_reg;
    logic                 busy_reg;

    logic                 accept;
    logic signed [WS-1:0] mux_smp;
    logic signed [WC-1:0] mux_coef;
    logic signed [WP-1:0] prod;
    logic signed [WS-1:0] sat_y;
    logic                 sat_ovf;

    // Only IDLE accepts a start. The result cycle that follows OUT is already
    // IDLE, which keeps start-to-start spacing at five cycles.
    assign accept = (state_reg == IDLE) && start;

    // ---------------- FSM -----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = MAC0;
            MAC0:    state_next = MAC1;
            MAC1:    state_next = MAC2;
            MAC2:    state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- shared multiplier -----------------
    always_comb begin
        mux_smp  = smp_reg[0];
        mux_coef = coef_reg[0];
        case (state_reg)
            MAC1: begin
                mux_smp  = smp_reg[1];
                mux_coef = coef_reg[1];
            end
            MAC2: begin
                mux_smp  = smp_reg[2];
                mux_coef = coef_reg[2];
            end
            default: ;
        endcase
    end

    assign prod = mux_smp * mux_coef;

    // ---------------- datapath registers -----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                smp_reg[i]  <= '0;
                coef_reg[i] <= '0;
            end
            acc_reg <= '0;
        end else if (accept) begin
            // Operands are frozen here so upstream shifting during the
            // computation cannot disturb the result.
            smp_reg[0]  <= fk;
            smp_reg[1]  <= fk_1;
            smp_reg[2]  <= fk_2;
            coef_reg[0] <= c0;
            coef_reg[1] <= c1;
            coef_reg[2] <= c2;
            acc_reg     <= '0;
        end else if (state_reg == MAC0 || state_reg == MAC1 || state_reg == MAC2) begin
            acc_reg <= acc_reg + {{(WA-WP){prod[WP-1]}}, prod};
        end
    end

    saturador_fk #(
        .W_IN  (WA),
        .W_OUT (WS),
        .SHIFT (F)
    ) u_sat (
        .acc     (acc_reg),
        .y_sat   (sat_y),
        .ovf_sat (sat_ovf)
    );

    // ---------------- outputs -----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_reg    <= '0;
            ovf_reg  <= 1'b0;
            done_reg <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == OUT);
            // busy spans MAC0..OUT plus the cycle in which done is shown.
            busy_reg <= (state_next != IDLE) || (state_reg == OUT);
            if (state_reg == OUT) begin
                y_reg   <= sat_y;
                ovf_reg <= sat_ovf;
            end
        end
    end

    assign y    = y_reg;
    assign ovf  = ovf_reg;
    assign done = done_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_filtro_mac_fk.sv
module tb_filtro_mac_fk;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [49:0] fk, fk_1, fk_2;
    logic signed [24:0] c0, c1, c2;
    logic signed [49:0] y;
    logic               done, busy, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic signed [24:0] ONE  = 25'sd1048576;   // 1.0
    localparam logic signed [24:0] HALF = 25'sd524288;    // 0.5
    localparam logic signed [24:0] QTR  = 25'sd262144;    // 0.25
    localparam logic signed [24:0] CMAX = 25'sd16777215;  // 2^24-1
    localparam logic signed [49:0] SMAX = 50'sd562949953421311;   // 2^49-1
    localparam logic signed [49:0] SMIN = -50'sd562949953421312;  // -2^49

    filtro_mac_fk #(.N(25), .F(20)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .fk    (fk),
        .fk_1  (fk_1),
        .fk_2  (fk_2),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .y     (y),
        .done  (done),
        .busy  (busy),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic signed [49:0] a0, input logic signed [49:0] a1,
                           input logic signed [49:0] a2, input logic signed [24:0] k0,
                           input logic signed [24:0] k1, input logic signed [24:0] k2);
        fk = a0; fk_1 = a1; fk_2 = a2;
        c0 = k0; c1 = k1; c2 = k2;
    endtask

    // One full transaction with cycle-exact timing checks.
    task automatic run_op(input string tag,
                          input logic signed [49:0] a0, input logic signed [49:0] a1,
                          input logic signed [49:0] a2, input logic signed [24:0] k0,
                          input logic signed [24:0] k1, input logic signed [24:0] k2,
                          input longint exp_y, input longint exp_ovf);
        set_ops(a0, a1, a2, k0, k1, k2);
        start = 1'b1;
        tick();                       // edge t
        start = 1'b0;
        check_val({tag, "_busy_t"}, longint'(busy), 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_val({tag, "_done_early"}, longint'(done), 0);
        end
        tick();                       // edge t+4
        check_val({tag, "_done"}, longint'(done), 1);
        check_val({tag, "_y"}, longint'(y), exp_y);
        check_val({tag, "_ovf"}, longint'(ovf), exp_ovf);
        check_val({tag, "_busy_t4"}, longint'(busy), 1);
        tick();                       // edge t+5
        check_val({tag, "_done_fall"}, longint'(done), 0);
        check_val({tag, "_busy_fall"}, longint'(busy), 0);
        check_val({tag, "_y_hold"}, longint'(y), exp_y);
        $display("op %s y=%0d ovf=%0d exp_y=%0d exp_ovf=%0d", tag, y, ovf, exp_y, exp_ovf);
    endtask

    int done_cnt;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_y", longint'(y), 0);
        check_val("rst_ovf", longint'(ovf), 0);
        check_val("rst_done", longint'(done), 0);
        check_val("rst_busy", longint'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        run_op("basic", 100, 200, 300, ONE, ONE, ONE, 600, 0);
        run_op("half_neg", -8, 0, 0, HALF, 0, 0, -4, 0);
        run_op("floor_m1", -1, 0, 0, HALF, 0, 0, -1, 0);
        run_op("floor_p", 7, 0, 0, HALF, 0, 0, 3, 0);
        run_op("mixed", 1000, -3000, 500, QTR, HALF, -ONE, -1750, 0);
        run_op("sat_pos", SMAX, SMAX, SMAX, CMAX, CMAX, CMAX, SMAX, 1);
        run_op("sat_neg", SMIN, SMIN, SMIN, CMAX, CMAX, CMAX, SMIN, 1);
        run_op("after_sat", 1, 2, 3, ONE, ONE, ONE, 6, 0);

        // Capture and ignore: operands change and start re-pulses while busy.
        set_ops(10, 20, 30, ONE, ONE, ONE);
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        set_ops(1000, 2000, 3000, ONE, ONE, ONE);
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            tick();
            if (done) begin
                done_cnt++;
                check_val("cap_y", longint'(y), 60);
            end
        end
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check_val("cap_done_cnt", longint'(done_cnt), 1);
        check_val("cap_y_hold", longint'(y), 60);
        $display("op capture y=%0d done_cnt=%0d", y, done_cnt);
        run_op("next_start", 1000, 2000, 3000, ONE, ONE, ONE, 6000, 0);

        // Reset while in MAC1.
        run_op("pre_rst", -50, 0, 0, HALF, 0, 0, -25, 0);
        set_ops(40, 50, 60, ONE, ONE, ONE);
        start = 1'b1;
        tick();                       // now MAC0
        start = 1'b0;
        tick();                       // now MAC1
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", longint'(busy), 0);
        check_val("mid_rst_done", longint'(done), 0);
        check_val("mid_rst_y", longint'(y), 0);
        check_val("mid_rst_ovf", longint'(ovf), 0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check_val("mid_rst_no_done", longint'(done_cnt), 0);
        check_val("mid_rst_busy_idle", longint'(busy), 0);
        $display("op mid_reset done_cnt=%0d y=%0d", done_cnt, y);
        run_op("post_rst", 40, 50, 60, ONE, ONE, ONE, 150, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
